fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  - IF stage plus IF/ID pipeline register of the 5-stage RV32I core.
//  - Owns PCF and drives the synchronous (1-cycle latency) instruction BRAM.
//  - Presents InstrD/PCD/PCPlus4D to Decode.
//  - Obeys stallF/stallD/FlushD from the hazard unit and redirect from Execute.
//  - Inserts NOP bubbles on flush and after reset.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PCF value loaded on reset
//  IMEM_AW   10             instruction BRAM word-address width (4*2^IMEM_AW bytes)
//  NOP_INSTR 32'h0000_0013  encoding driven on InstrD when ValidD=0 (addi x0,x0,0)
// PORTS
//  clk        in   1        single clock, all flops rising edge
//  reset      in   1        asynchronous, active-low (reset==0 resets)
//  stallF     in   1        hold PCF
//  stallD     in   1        hold IF/ID register
//  stallE     in   1        E stage held; qualifies PcSrcE/FlushD
//  FlushD     in   1        kill IF/ID contents (bubble)
//  PcSrcE     in   1        branch/jump taken in Execute
//  PCTargetE  in   32       redirect target from Execute
//  imem_addr  out  IMEM_AW  BRAM word address = PCF[IMEM_AW+1:2], combinational
//  imem_en    out  1        BRAM read enable
//  imem_rdata in   32       BRAM read data, valid 1 cycle after addr/en
//  InstrD     out  32       instruction in Decode (NOP_INSTR when !ValidD)
//  PCD        out  32       PC of InstrD
//  PCPlus4D   out  32       PCD+4
//  ValidD     out  1        IF/ID holds a real instruction
// BEHAVIOUR
//  - Reset (async): PCF=RESET_PC, PCD=0, PCPlus4D=0, ValidD=0, InstrD=NOP_INSTR, imem_en=0.
//  - redirect = PcSrcE & ~stallE; kill = FlushD & ~stallE.
//    A held E instruction never redirects or flushes.
//  - PCF next, by priority:
//    - redirect -> {PCTargetE[31:2],2'b00} (low bits forced to 0);
//    - else stallF -> hold;
//    - else PCF+4 (mod 2^32: 32'hFFFF_FFFC -> 0).
//  - IF/ID next, by priority:
//    - kill -> ValidD=0, PCD/PCPlus4D hold;
//    - else stallD -> hold all;
//    - else PCD=PCF, PCPlus4D=PCF+4, ValidD=1.
//  - Instruction data is the BRAM output register, aligned with PCD; InstrD = ValidD ? instr_raw : NOP_INSTR.
//  - Latency: addr presented in cycle t -> InstrD valid in t+1. First valid InstrD is at the 1st edge after reset release.
//  - imem_en = reset & ~stallD (base build). While stalled, the BRAM output reg holds the D instruction.
//  - Stall+kill in the same cycle: kill wins. Redirect+stallF: redirect wins.
//  - Reset asserted mid-operation: all state cleared immediately. No partial fetch survives.
// CONFIGURATION
//  IF_SKID_BUF_EN defined:
//    - imem_en = reset (always enabled, for BRAM macros without a usable enable).
//    - On the first cycle with stallD & ~kill, capture imem_rdata into skid_q and set skid_vld=1.
//    - While skid_vld: instr_raw = skid_q.
//    - skid_vld clears on stall release or kill. Its reset value is 0.
//    - The BRAM re-reads mem[PCF] during the stall, so its output is correct at release.
//  IF_SKID_BUF_EN undefined:
//    - No skid register; instr_raw = imem_rdata.
//    - imem_en = reset & ~stallD.
//  Cycle-level InstrD/PCD/ValidD behaviour is identical in both builds.
// TESTING
//  T1 reset release, mem[0..2]=A,B,C, no stalls:
//     InstrD = NOP, A, B, C on successive edges; PCD=0,0,4,8 with ValidD=0,1,1,1.
//  T2 stallF=stallD=1 for 2 cycles while InstrD=B (PCD=4):
//     InstrD=B, PCD=4, PCF=8 held for both cycles; C appears on the 1st edge after release.
//  T3 PcSrcE=1, FlushD=1, PCTargetE=32'h40 while PCF=0x10:
//     next edge gives PCF=0x40, ValidD=0, InstrD=NOP; following edge gives InstrD=mem[0x40], PCD=0x40.
//  T4 PcSrcE=FlushD=1 with stallE=1:
//     no redirect, no bubble; PCF/IF/ID behave per stallF/stallD.
//  T5 PCF=32'hFFFF_FFFC, no stall, no redirect:
//     next PCF=0; PCPlus4D=0 when that PC reaches D.
//  T6 reset pulled low mid-stream and held during a stall:
//     outputs go to reset values immediately; fetch restarts at RESET_PC.
//  Run all tests with and without IF_SKID_BUF_EN against a BRAM model that has a real enable.
//  For the IF_SKID_BUF_EN build, also use a BRAM model that ignores en; T2 must still pass.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I IF stage with IF/ID register; IF_SKID_BUF_EN selects the skid-buffered always-enabled BRAM variant
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned IMEM_AW   = 10,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stallF,
  input  logic               stallD,
  input  logic               stallE,
  input  logic               FlushD,
  input  logic               PcSrcE,
  input  logic [31:0]        PCTargetE,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_en,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        InstrD,
  output logic [31:0]        PCD,
  output logic [31:0]        PCPlus4D,
  output logic               ValidD
);

  logic [31:0] pc_f;
  logic [31:0] pc_f_next;
  logic [31:0] pc_plus4_f;
  logic        redirect;
  logic        kill;
  logic [31:0] instr_raw;

  // A held Execute instruction must neither redirect nor flush
  assign redirect   = PcSrcE & ~stallE;
  assign kill       = FlushD & ~stallE;
  assign pc_plus4_f = pc_f + 32'd4;
  assign imem_addr  = pc_f[IMEM_AW+1:2];

  // Next PC: redirect beats stall, otherwise sequential (wraps mod 2^32)
  always_comb begin
    pc_f_next = pc_plus4_f;
    if (redirect) begin
      pc_f_next = PCTargetE & ~32'd3;
    end else if (stallF) begin
      pc_f_next = pc_f;
    end
  end

  // PC register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f <= RESET_PC;
    end else begin
      pc_f <= pc_f_next;
    end
  end

  // IF/ID register: kill beats stall; the BRAM output reg supplies the matching instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (kill) begin
      ValidD <= 1'b0;
    end else if (!stallD) begin
      PCD      <= pc_f;
      PCPlus4D <= pc_plus4_f;
      ValidD   <= 1'b1;
    end
  end

`ifdef IF_SKID_BUF_EN
  logic [31:0] skid_q;
  logic        skid_vld;

  // BRAM keeps reading during a stall, so the Decode instruction is parked here
  assign imem_en = reset;

  // Capture the Decode instruction on the first stalled cycle; drop it on release or kill
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_q   <= '0;
      skid_vld <= 1'b0;
    end else if (kill || !stallD) begin
      skid_vld <= 1'b0;
    end else if (!skid_vld) begin
      skid_q   <= imem_rdata;
      skid_vld <= 1'b1;
    end
  end

  assign instr_raw = skid_vld ? skid_q : imem_rdata;
`else
  // Disabling the BRAM while Decode stalls keeps its output reg holding the Decode instruction
  assign imem_en   = reset & ~stallD;
  assign instr_raw = imem_rdata;
`endif

  assign InstrD = ValidD ? instr_raw : NOP_INSTR;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized scoreboard bench for fetch_stage against a PC/IF-ID reference model
module tb_fetch_stage;

  localparam int          AW  = 10;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stallF = 1'b0, stallD = 1'b0, stallE = 1'b0;
  logic          FlushD = 1'b0, PcSrcE = 1'b0;
  logic [31:0]   PCTargetE = '0;
  logic [AW-1:0] imem_addr;
  logic          imem_en;
  logic [31:0]   imem_rdata = '0;
  logic [31:0]   InstrD, PCD, PCPlus4D;
  logic          ValidD;

  logic [31:0] mem [0:(1<<AW)-1];
  logic        ignore_en = 1'b0;
  bit          skid_build;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pcp4;
    logic        valid;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_pcf, m_pcd, m_pcp4;
  logic        m_valid;

  fetch_stage #(.RESET_PC(RPC), .IMEM_AW(AW), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .FlushD(FlushD), .PcSrcE(PcSrcE), .PCTargetE(PCTargetE),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  // Synchronous BRAM; optionally blind to its enable
  always @(posedge clk) begin
    if (imem_en || ignore_en) imem_rdata <= mem[imem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pcf = RPC; m_pcd = '0; m_pcp4 = '0; m_valid = 1'b0;
  endtask

  // Reference: PC and IF/ID slot advance by the priority rules; the instruction is looked up from mem
  task automatic model_step(input logic r, sf, sd, se, fd, ps, input logic [31:0] tgt);
    exp_t e;
    logic redir, k;
    logic [31:0] npc;
    if (!r) begin
      model_reset();
    end else begin
      redir = ps && !se;
      k     = fd && !se;
      npc   = redir ? (tgt / 4) * 4 : (sf ? m_pcf : m_pcf + 32'd4);
      if (k) m_valid = 1'b0;
      else if (!sd) begin
        m_pcd = m_pcf; m_pcp4 = m_pcf + 32'd4; m_valid = 1'b1;
      end
      m_pcf = npc;
    end
    e.valid = m_valid;
    e.pcd   = m_pcd;
    e.pcp4  = m_pcp4;
    e.instr = m_valid ? mem[m_pcd[AW+1:2]] : NOP;
    sb.push_back(e);
  endtask

  task automatic drive(input logic r, sf, sd, se, fd, ps, input logic [31:0] tgt);
    logic [31:0] a;
    @(negedge clk);
    reset = r; stallF = sf; stallD = sd; stallE = se; FlushD = fd; PcSrcE = ps; PCTargetE = tgt;
    #1;
    if (!r) begin
      model_reset();
      chk("rst_ValidD", {31'b0, ValidD}, 32'd0);
      chk("rst_InstrD", InstrD, NOP);
      chk("rst_PCD", PCD, 32'd0);
      chk("rst_PCPlus4D", PCPlus4D, 32'd0);
    end
    a = m_pcf;
    chk("imem_addr", {{(32-AW){1'b0}}, imem_addr}, {{(32-AW){1'b0}}, a[AW+1:2]});
    chk("imem_en", {31'b0, imem_en}, {31'b0, r & (skid_build | ~sd)});
    model_step(r, sf, sd, se, fd, ps, tgt);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 32'h0);
  endtask

  // Monitor: compare each post-edge output set against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ValidD", {31'b0, ValidD}, {31'b0, e.valid});
        chk("InstrD", InstrD, e.instr);
        chk("PCD", PCD, e.pcd);
        chk("PCPlus4D", PCPlus4D, e.pcp4);
      end
    end
  end

  task automatic directed();
    // reset release, straight-line fetch
    drive(0, 0, 0, 0, 0, 0, 0);
    run(2);
    // stall both while B is in Decode
    drive(1, 1, 1, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 0);
    run(2);
    // redirect with flush from PCF=0x10
    drive(1, 0, 0, 0, 1, 1, 32'h0000_0041);
    run(2);
    // held Execute: neither redirect nor bubble
    drive(1, 0, 0, 1, 1, 1, 32'h0000_0200);
    drive(1, 1, 1, 1, 1, 1, 32'h0000_0300);
    run(1);
    // PC wrap at the top of the address space
    drive(1, 0, 0, 0, 1, 1, 32'hFFFF_FFFE);
    run(3);
    // reset asserted during a stall
    drive(1, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0);
    run(3);
  endtask

  task automatic random_phase(input int n);
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      t = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      drive(($urandom_range(0, 60) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0), t);
    end
  endtask

  initial begin
`ifdef IF_SKID_BUF_EN
    skid_build = 1'b1;
`else
    skid_build = 1'b0;
`endif
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    model_reset();
    directed();
    random_phase(400);
    if (skid_build) begin
      ignore_en = 1'b1;
      directed();
      random_phase(400);
    end
    run(2);
    @(negedge clk);
    chk("sb_drain", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
